// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low key matrix scanner with frame-based debounce.
// One column is driven low at a time; the synchronised rows are gathered into
// a 16-key frame image that is classified once per full scan (NONE, SINGLE or
// GHOST) and fed to a debounce FSM. An accepted press gives a one-cycle
// key_valid strobe with the key code (row_idx*4 + col_idx).
// Optional build macro: KEYPAD_REPEAT_EN adds an auto-repeat frame counter
// that re-strobes key_valid every REPEAT_FRAMES frames while a key is held.
//
// Strobe semantics: key_valid is a pure one-cycle pulse with no back-pressure;
// key_code is stable from the cycle key_valid rises until the next acceptance.
module keypad_scan #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_TARGET = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       col_idx;
    logic             frame_done;
    logic [2:0][3:0]  col_rows;    // pressed rows (active high) of columns 0..2
    logic [15:0]      frame_keys;  // whole-frame image indexed by key code
    logic [4:0]       n_keys;
    logic [3:0]       key_idx;
    logic             frame_none;
    logic             frame_single;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [3:0]       cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       cand_nxt;
    logic             accept;
    logic             rep_pulse;

    // Two-flop synchroniser: the matrix rows are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Column prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_done = tick && (col_idx == 2'd3);

    // Column index advances on every tick, wrapping 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx <= 2'd0;
        end else if (tick) begin
            col_idx <= col_idx + 2'd1;
        end
    end

    // Registered column drive; it trails col_idx by one cycle so every column
    // is visible for exactly SCAN_DIV cycles, the first one right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= 4'b1111;
        end else begin
            col <= ~(4'b0001 << col_idx);
        end
    end

    // Frame buffer for columns 0..2; column 3 is taken live at frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_rows <= '0;
        end else if (tick) begin
            case (col_idx)
                2'd0:    col_rows[0] <= ~row_sync;
                2'd1:    col_rows[1] <= ~row_sync;
                2'd2:    col_rows[2] <= ~row_sync;
                default: ;
            endcase
        end
    end

    // Assemble the frame image in key-code order (row*4 + col).
    always_comb begin
        frame_keys = '0;
        for (int r = 0; r < 4; r++) begin
            frame_keys[r*4 + 0] = col_rows[0][r];
            frame_keys[r*4 + 1] = col_rows[1][r];
            frame_keys[r*4 + 2] = col_rows[2][r];
            frame_keys[r*4 + 3] = ~row_sync[r];
        end
    end

    // Classify the frame: key count plus the index of a lone key.
    always_comb begin
        n_keys  = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_keys[i]) begin
                n_keys  = n_keys + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign frame_none   = (n_keys == 5'd0);
    assign frame_single = (n_keys == 5'd1);
    assign cnt_inc      = cnt + 4'd1;

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    // Debounce FSM next state; it only moves on frame_done. A press is accepted
    // the moment the run of identical frames reaches DEBOUNCE_FRAMES.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (frame_done) begin
            case (state)
                ST_IDLE: begin
                    if (frame_single) begin
                        cand_nxt = key_idx;
                        cnt_nxt  = 4'd1;
                        if (DEB_TARGET == 4'd1) begin
                            state_nxt = ST_HELD;
                            accept    = 1'b1;
                        end else begin
                            state_nxt = ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (frame_single && (key_idx == cand)) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_TARGET) begin
                            state_nxt = ST_HELD;
                            accept    = 1'b1;
                        end
                    end else if (frame_single) begin
                        // A different lone key restarts the run for that key.
                        cand_nxt = key_idx;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                ST_HELD: begin
                    // Only an empty frame starts a release; other keys are ignored.
                    if (frame_none) begin
                        cnt_nxt = 4'd1;
                        if (DEB_TARGET == 4'd1) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_RELEASE_WAIT;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (frame_none) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_TARGET) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = 4'd0;
                        end
                    end else begin
                        // Bounce during release: back to held, no new strobe.
                        state_nxt = ST_HELD;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic [REP_W-1:0] rep_inc;

    assign rep_inc = rep_cnt + REP_W'(1);

    // Auto-repeat: count frames spent held; freeze while a release is pending.
    always_comb begin
        rep_cnt_nxt = rep_cnt;
        rep_pulse   = 1'b0;
        if (accept) begin
            rep_cnt_nxt = '0;
        end else if (frame_done && (state == ST_HELD) && (state_nxt == ST_HELD)) begin
            if (rep_inc == REP_LAST) begin
                rep_cnt_nxt = '0;
                rep_pulse   = 1'b1;
            end else begin
                rep_cnt_nxt = rep_inc;
            end
        end
    end

    // Repeat frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nxt;
        end
    end
`else
    // No auto-repeat: exactly one strobe per accepted press.
    logic unused_repeat_cfg;
    assign rep_pulse         = 1'b0;
    assign unused_repeat_cfg = ^REPEAT_FRAMES;
`endif

    // Registered outputs: strobe the cycle after acceptance, hold the code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= accept | rep_pulse;
            if (accept) begin
                key_code <= cand_nxt;
            end
            key_held <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE_WAIT);
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a behavioural key
// matrix (a held key pulls its row low while its column is driven low).
// Expected key codes are queued when a press is issued and a monitor pops one
// per key_valid strobe; any strobe with nothing queued is an error.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 8;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = DEB * FRAME + FRAME + 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys_down;

    int          checks;
    int          failures;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;
    logic [3:0]  col_tab[4];

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB),
        .REPEAT_FRAMES  (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Clock and matrix model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4 + c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a key_valid strobe; the monitor checks its code.
    task automatic wait_strobe(input string name, input int bound);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (n < bound && !seen) begin
            @(negedge clk);
            n++;
            if (key_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s strobe=none required_within=%0d cycles", name, bound);
        end
    endtask

    // Wait until a new scan frame has just started (col 0111 -> 1110).
    task automatic align_frame();
        logic [3:0] prev;
        int         n;
        bit         found;
        prev  = col;
        n     = 0;
        found = 1'b0;
        while (n < 4 * FRAME && !found) begin
            @(negedge clk);
            n++;
            if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
            prev = col;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_align col=%b required=frame_start", col);
        end
    endtask

    // Scoreboard monitor: one queued code per strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe key_code=%0d expected=no_strobe at %0t", key_code, $time);
            end else begin
                exp_code = exp_q.pop_front();
                check("strobe_code", key_code, exp_code);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        keys_down = '0;
        rst_n     = 1'b0;
        col_tab   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset state.
        wait_cycles(3);
        check("reset_col", col, 4'b1111);
        check("reset_key_code", key_code, 4'd0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_held", key_held, 1'b0);

        // Idle scan sequence after reset release.
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check("col_seq", col, col_tab[((k - 1) / 4) % 4]);
        end
        check("idle_key_held", key_held, 1'b0);

        // Bouncy key 6: 2 frames down, 1 up, 2 down -> never accepted.
        keys_down[6] = 1'b1;
        wait_cycles(2 * FRAME);
        keys_down[6] = 1'b0;
        wait_cycles(FRAME);
        keys_down[6] = 1'b1;
        wait_cycles(2 * FRAME);
        keys_down[6] = 1'b0;
        wait_cycles(5 * FRAME);
        check("bounce_key_code", key_code, 4'd0);
        check("bounce_key_held", key_held, 1'b0);

        // Key 6 held 6 frames: one strobe within latency, held until release debounced.
        keys_down[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_strobe("press_latency_k6", LAT);
        wait_cycles(1);
        check("k6_held_after_accept", key_held, 1'b1);
        wait_cycles(3 * FRAME);
        keys_down[6] = 1'b0;
        wait_cycles(2 * FRAME);
        check("k6_held_during_release", key_held, 1'b1);
        wait_cycles(LAT - 2 * FRAME);
        check("k6_released", key_held, 1'b0);

        // Release gap of 2 frames then re-press: still a single strobe.
        keys_down[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_strobe("press_latency_k6_gap", LAT);
        wait_cycles(2 * FRAME);
        keys_down[6] = 1'b0;
        wait_cycles(24);
        check("gap_held_release", key_held, 1'b1);
        wait_cycles(2 * FRAME - 24);
        keys_down[6] = 1'b1;
        wait_cycles(FRAME);
        check("gap_held_repress", key_held, 1'b1);
        wait_cycles(FRAME);
        keys_down[6] = 1'b0;
        wait_cycles(24);
        check("gap_held_final_release", key_held, 1'b1);
        wait_cycles(LAT - 24);
        check("gap_released", key_held, 1'b0);

        // Ghosting: keys 0 and 5 together are rejected; key 0 alone is accepted.
        keys_down[0] = 1'b1;
        keys_down[5] = 1'b1;
        wait_cycles(6 * FRAME);
        check("ghost_key_held", key_held, 1'b0);
        check("ghost_key_code", key_code, 4'd6);
        keys_down[5] = 1'b0;
        exp_q.push_back(4'd0);
        wait_strobe("press_latency_k0", LAT);
        wait_cycles(1);
        check("k0_key_code", key_code, 4'd0);
        keys_down = '0;
        wait_cycles(LAT);
        check("k0_released", key_held, 1'b0);

        // Key 15 held 30 frames after acceptance.
        keys_down[15] = 1'b1;
        exp_q.push_back(4'd15);
        wait_strobe("press_latency_k15", LAT);
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd15);
`endif
        wait_cycles(30 * FRAME);
        keys_down = '0;
        wait_cycles(LAT);
        check("k15_released", key_held, 1'b0);
        check("k15_strobes_pending", exp_q.size(), 0);

        // Reset pulsed mid-debounce (after two matching frames) -> no strobe.
        align_frame();
        keys_down[15] = 1'b1;
        wait_cycles(38);
        rst_n = 1'b0;
        wait_cycles(1);
        check("midreset_col", col, 4'b1111);
        check("midreset_key_valid", key_valid, 1'b0);
        check("midreset_key_held", key_held, 1'b0);
        check("midreset_key_code", key_code, 4'd0);
        keys_down = '0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(6 * FRAME);
        check("post_reset_key_code", key_code, 4'd0);
        check("post_reset_key_held", key_held, 1'b0);
        check("missing_strobes", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
